ahb_sram_ctrl: RTL and testbench
================================

# ahb_sram_ctrl

Parametrised AHB-Lite slave controller for a single-port synchronous SRAM macro (`sp_memory` class, 1-cycle read latency). It serves every in-range, aligned transfer, read or write, with zero wait states. HSIZE-decoded byte strobes give true sub-word writes. A one-entry posted-write buffer with read-after-write forwarding resolves port conflicts. The block sits between the AHB-Lite interconnect and the memory core; the memory instance lives outside the block.

## Interface
- `WIDTH`, 32: data width in bits; one of 32, 64, 128.
- `DEPTH`, 1024: memory depth in words; power of two.
- `AW`, `$clog2(DEPTH)`: word-address width (derived).
- `BL`, `$clog2(WIDTH/8)`: byte-lane index bits (derived).
- `hclk` in 1: clock.
- `hresetn` in 1: reset, asynchronous, active-low.
- `hsel` in 1: slave select.
- `haddr` in 32: byte address.
- `htrans` in 2: transfer type; bit 1 set means NONSEQ/SEQ.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: transfer size, log2 of bytes.
- `hwdata` in WIDTH: write data, valid in data phase.
- `hready` in 1: bus HREADY (HREADY_IN).
- `hreadyout` out 1: slave ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out WIDTH: read data.
- `mem_cs`, `mem_we` out 1: memory select and write enable.
- `mem_addr` out AW: word address.
- `mem_wdata` out WIDTH: write data to memory.
- `mem_wstrb` out WIDTH/8: byte write enables.
- `mem_rdata` in WIDTH: memory read data, valid the cycle after a read access.
- `wbuf_pending` out 1: posted-write buffer holds uncommitted data.

## Operation
- Accepted transfer: `hsel & hready & htrans[1]`. BUSY and IDLE get zero-wait OKAY with no memory access.
- Byte strobes come from `hsize` and `haddr[BL-1:0]`: 2^hsize contiguous lanes starting at the aligned lane, little-endian. Strobes are captured with the address-phase registers (word address, strobes, write flag).
- **Read:** issued to memory in the address phase: `mem_cs=1`, `mem_we=0`, `mem_addr=haddr[AW+BL-1:BL]`. A read always has port priority.
- **Write, data phase:**
  - If the port is free (no read address phase this cycle), commit directly: `mem_we=1`, `mem_wdata=hwdata`, strobes as captured.
  - Otherwise latch address, strobes and `hwdata` into the buffer and set `wbuf_pending`.
- **Buffer drain:** a pending buffer commits in the first cycle in which the port is free. A buffered write and a direct write never coexist: the buffer fills only in a read address-phase cycle, the next write data phase needs a preceding write address phase, and that free cycle drains the buffer. A single entry is therefore sufficient, and no write ever stalls.
- **Forwarding:**
  - At a read address phase, compare its word address against the pending buffer and against the write in its data phase this cycle.
  - Register the byte hit mask (the matching strobes).
  - In the read data phase: `hrdata` lane = buffer lane if the mask bit is set, else the `mem_rdata` lane.
- `hrdata` is 0 in every cycle that is not an OKAY read data phase.
- Reset mid-operation discards the buffer contents: a posted but uncommitted write is lost.

## Timing
- Reset values: `hreadyout=1`, `hresp=0`, `hrdata=0`, `mem_cs=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wstrb=0`, `wbuf_pending=0`.
- Read latency: address phase in cycle N, data in cycle N+1 with `hreadyout=1`.
- Write: the memory write occurs in data phase N+1, or in the first later free cycle.
- `hready=0` from another slave: no new address phase is accepted, so the port is free and a pending buffer drains.
- The ERROR response takes two cycles (see Configuration). Neither cycle accesses memory, and a pending buffer drains during them.
- Back-to-back W,R,W,R… to the same word runs at full rate, and every read returns the latest written bytes.

## Configuration
- `AHB_SRAM_ERR_EN` defined:
  - These transfers get the AHB two-cycle ERROR: out-of-range address (`haddr >= DEPTH*WIDTH/8`), `hsize > BL`, or misalignment (`haddr` not a multiple of 2^hsize).
  - Response: cycle 1 `hreadyout=0`, `hresp=1`; cycle 2 `hreadyout=1`, `hresp=1`.
  - No memory access; a write's data is discarded.
- Undefined:
  - `hresp` tied 0 and no checks.
  - Address upper bits are ignored, so addresses wrap modulo DEPTH.
  - `hsize > BL` is treated as full width.
  - Misaligned transfers use strobes truncated at the top lane.

## Test plan
- Word write 0xDEADBEEF to 0x10, then read 0x10 → zero-wait read, `hrdata=0xDEADBEEF`; exactly one `mem_we` pulse, with `mem_wstrb=4'hF`.
- Byte writes 0x11 to 0x21 and halfword 0xAABB to 0x22 over 0x00000000 → `mem_wstrb` 4'b0010 then 4'b1100; a read of 0x20 returns 0xAABB1100.
- W(0x40, 0x12345678) immediately followed by R(0x40) → `wbuf_pending=1` for one cycle, and the read returns 0x12345678 via forwarding.
- Sustained alternating W/R to 8 addresses for 64 transfers → `hreadyout` never low, all reads match the model, and the buffer never overflows.
- With `AHB_SRAM_ERR_EN` and DEPTH=1024, WIDTH=32: write 0x1000 → two-cycle ERROR, no `mem_cs`; a halfword at 0x3 also gets ERROR. Without the macro, 0x1000 aliases word 0.
- Assert `hresetn` while `wbuf_pending=1` → all outputs at reset values, and the buffered write is not committed.

Source files
------------

// File: rtl/ahb_sram_ctrl.sv
// Zero-wait AHB-Lite slave for a 1-cycle-latency single-port SRAM, with a one-entry posted-write
// buffer and read-after-write forwarding. Define AHB_SRAM_ERR_EN for range/size/alignment ERRORs.
module ahb_sram_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int BL    = $clog2(WIDTH / 8)
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               hsel,
    input  logic [31:0]        haddr,
    input  logic [1:0]         htrans,
    input  logic               hwrite,
    input  logic [2:0]         hsize,
    input  logic [WIDTH-1:0]   hwdata,
    input  logic               hready,
    output logic               hreadyout,
    output logic               hresp,
    output logic [WIDTH-1:0]   hrdata,
    output logic               mem_cs,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH/8-1:0] mem_wstrb,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               wbuf_pending
);
    localparam int NB = WIDTH / 8;

    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

    state_t           state_q, state_d;
    logic             hreadyout_q, hreadyout_d;
    logic             hresp_q, hresp_d;
    logic             rd_dphase_q, rd_dphase_d;
    logic             wr_dphase_q, wr_dphase_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [NB-1:0]    strb_q, strb_d;
    logic             wbuf_pending_q, wbuf_pending_d;
    logic [AW-1:0]    wbuf_addr_q, wbuf_addr_d;
    logic [NB-1:0]    wbuf_strb_q, wbuf_strb_d;
    logic [WIDTH-1:0] wbuf_data_q, wbuf_data_d;
    logic [NB-1:0]    hit_q, hit_d;

    logic             acc, bad_xfer, err_det, rd_acc, wr_acc;
    logic             direct_wr, fill, drain;
    logic [AW-1:0]    req_addr;
    logic [NB-1:0]    req_strb;
    logic [WIDTH-1:0] merged;
    logic             unused_bits;

    // 2^size lanes from the addressed lane upward; oversize clamps to full width, overflow is dropped.
    function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [BL-1:0] lane);
        logic [2*NB-1:0] ones;
        logic [2*NB-1:0] shifted;
        int              nbytes;
        nbytes = (32'(size) > 32'(BL)) ? NB : (1 << size);
        ones   = '0;
        for (int i = 0; i < NB; i++) begin
            ones[i] = (i < nbytes);
        end
        shifted = ones << lane;
        return shifted[NB-1:0];
    endfunction

`ifdef AHB_SRAM_ERR_EN
    always_comb begin
        bad_xfer = (32'(hsize) > 32'(BL))
                 | ((haddr >> (AW + BL)) != 32'd0)
                 | ((haddr & ((32'd1 << hsize) - 32'd1)) != 32'd0);
    end
`else
    assign bad_xfer = 1'b0;
`endif

    assign unused_bits = ^{htrans[0], haddr[31:AW+BL]};

    always_comb begin
        acc       = hresetn & hsel & hready & htrans[1];
        err_det   = acc & bad_xfer;
        req_addr  = haddr[AW+BL-1:BL];
        req_strb  = lane_mask(hsize, haddr[BL-1:0]);
        rd_acc    = acc & ~hwrite & ~err_det;
        wr_acc    = acc &  hwrite & ~err_det;
        // A read address phase owns the port; a colliding write data phase is parked in the buffer.
        direct_wr = wr_dphase_q & ~rd_acc;
        fill      = wr_dphase_q &  rd_acc;
        drain     = wbuf_pending_q & ~rd_acc & ~wr_dphase_q;
    end

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (rd_acc) begin
            mem_cs   = 1'b1;
            mem_addr = req_addr;
        end else if (direct_wr) begin
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = hwdata;
            mem_wstrb = strb_q;
        end else if (drain) begin
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wbuf_addr_q;
            mem_wdata = wbuf_data_q;
            mem_wstrb = wbuf_strb_q;
        end
    end

    always_comb begin
        rd_dphase_d    = rd_acc;
        wr_dphase_d    = wr_acc;
        addr_d         = wr_acc ? req_addr : addr_q;
        strb_d         = wr_acc ? req_strb : strb_q;
        wbuf_pending_d = fill | (wbuf_pending_q & ~drain);
        wbuf_addr_d    = fill ? addr_q : wbuf_addr_q;
        wbuf_strb_d    = fill ? strb_q : wbuf_strb_q;
        wbuf_data_d    = fill ? hwdata : wbuf_data_q;

        // Whichever write matches lives in the buffer during the read's data phase.
        hit_d = '0;
        if (rd_acc) begin
            if (wr_dphase_q && (addr_q == req_addr)) begin
                hit_d = hit_d | strb_q;
            end
            if (wbuf_pending_q && (wbuf_addr_q == req_addr)) begin
                hit_d = hit_d | wbuf_strb_q;
            end
        end

        state_d     = ST_OKAY;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
        case (state_q)
            ST_ERR1: begin
                state_d = ST_ERR2;
                hresp_d = 1'b1;
            end
            default: begin
                if (err_det) begin
                    state_d     = ST_ERR1;
                    hreadyout_d = 1'b0;
                    hresp_d     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q        <= ST_OKAY;
            hreadyout_q    <= 1'b1;
            hresp_q        <= 1'b0;
            rd_dphase_q    <= 1'b0;
            wr_dphase_q    <= 1'b0;
            addr_q         <= '0;
            strb_q         <= '0;
            wbuf_pending_q <= 1'b0;
            wbuf_addr_q    <= '0;
            wbuf_strb_q    <= '0;
            wbuf_data_q    <= '0;
            hit_q          <= '0;
        end else begin
            state_q        <= state_d;
            hreadyout_q    <= hreadyout_d;
            hresp_q        <= hresp_d;
            rd_dphase_q    <= rd_dphase_d;
            wr_dphase_q    <= wr_dphase_d;
            addr_q         <= addr_d;
            strb_q         <= strb_d;
            wbuf_pending_q <= wbuf_pending_d;
            wbuf_addr_q    <= wbuf_addr_d;
            wbuf_strb_q    <= wbuf_strb_d;
            wbuf_data_q    <= wbuf_data_d;
            hit_q          <= hit_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = hit_q[gi] ? wbuf_data_q[gi*8 +: 8] : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    assign hrdata       = rd_dphase_q ? merged : '0;
    assign hreadyout    = hreadyout_q;
    assign hresp        = hresp_q;
    assign wbuf_pending = wbuf_pending_q;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Randomised scoreboard bench for ahb_sram_ctrl: byte-level memory model, external SRAM model,
// and a bus monitor that checks every data phase. Expectations follow AHB_SRAM_ERR_EN when defined.
module tb_ahb_sram_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int NB    = 4;

    logic              hclk = 1'b0;
    logic              hresetn = 1'b1;
    logic              hsel = 1'b0;
    logic [31:0]       haddr = '0;
    logic [1:0]        htrans = 2'b00;
    logic              hwrite = 1'b0;
    logic [2:0]        hsize = 3'd0;
    logic [WIDTH-1:0]  hwdata = '0;
    logic              hready_in;
    logic              hreadyout, hresp;
    logic [WIDTH-1:0]  hrdata;
    logic              mem_cs, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [NB-1:0]     mem_wstrb;
    logic [WIDTH-1:0]  mem_rdata = '0;
    logic              wbuf_pending;

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cs_cnt = 0, we_cnt = 0, pend_cnt = 0, low_cnt = 0;
    logic [3:0]  strb_log[$];
    logic [31:0] last_rd = '0;
    logic [31:0] next_wdata = '0;

    logic [WIDTH-1:0] sram [DEPTH] = '{default: '0};
    logic [7:0]       ref_mem [DEPTH][NB] = '{default: '{default: 8'h00}};
    logic [WIDTH-1:0] bmask;

    always #5 hclk = ~hclk;
    assign hready_in = hreadyout;

    ahb_sram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_in),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .wbuf_pending(wbuf_pending)
    );

    // External single-port SRAM, one cycle read latency.
    always_comb begin
        bmask = '0;
        for (int b = 0; b < NB; b++) bmask[b*8 +: 8] = {8{mem_wstrb[b]}};
    end
    always @(posedge hclk) begin
        if (mem_cs && mem_we) sram[mem_addr] <= (sram[mem_addr] & ~bmask) | (mem_wdata & bmask);
        else if (mem_cs) mem_rdata <= sram[mem_addr];
    end

    always @(negedge hclk) begin
        if (hresetn) begin
            if (mem_cs) cs_cnt++;
            if (mem_cs && mem_we) begin
                we_cnt++;
                strb_log.push_back(mem_wstrb);
            end
            if (wbuf_pending) pend_cnt++;
            if (!hreadyout) low_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
`ifdef AHB_SRAM_ERR_EN
        return (a >= 32'(DEPTH * NB)) || (sz > 3'd2) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
`else
        return (a == 32'hFFFF_FFFF) && (sz == 3'd7) && 1'b0;
`endif
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int w, lane, n;
        w    = int'(a[11:2]);
        lane = int'(a[1:0]);
        n    = (sz > 3'd2) ? NB : (1 << sz);
        for (int k = 0; k < n; k++)
            if (lane + k < NB) ref_mem[w][lane + k] = d[(lane + k) * 8 +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        w = int'(a[11:2]);
        return {ref_mem[w][3], ref_mem[w][2], ref_mem[w][1], ref_mem[w][0]};
    endfunction

    function automatic void model_set(input logic [31:0] a, input logic [31:0] v);
        int w;
        w = int'(a[11:2]);
        for (int k = 0; k < NB; k++) ref_mem[w][k] = v[k*8 +: 8];
    endfunction

    // ---------------- scoreboard monitor ----------------
    initial begin : scoreboard
        bit   dp;
        exp_t e;
        dp = 1'b0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                dp = 1'b0;
                continue;
            end
            if (dp) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got data phase with empty queue, required a queued transfer");
                end else begin
                    e = exp_q.pop_front();
                    if (e.err) begin
                        check("err_cycle1", {30'd0, hreadyout, hresp}, 32'd1);
                        @(negedge hclk);
                        check("err_cycle2", {30'd0, hreadyout, hresp}, 32'd3);
                        $display("[TB] %s addr=%h ERROR", e.rd ? "RD" : "WR", e.addr);
                    end else begin
                        check("okay_resp", {30'd0, hreadyout, hresp}, 32'd2);
                        if (e.rd) begin
                            check("rdata", hrdata, e.data);
                            last_rd = hrdata;
                        end else begin
                            check("hrdata_wr_zero", hrdata, 32'd0);
                        end
                        $display("[TB] %s addr=%h hrdata=%h", e.rd ? "RD" : "WR", e.addr, hrdata);
                    end
                end
            end else begin
                check("hrdata_idle_zero", hrdata, 32'd0);
            end
            dp = hsel && hready_in && htrans[1];
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept();
        int guard;
        guard = 0;
        do begin
            @(negedge hclk);
            guard++;
        end while (!hreadyout && guard < 16);
        tests++;
        if (!hreadyout) begin
            fails++;
            $display("FAIL hready_timeout: hreadyout=%0b after %0d cycles, required 1", hreadyout, guard);
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input bit act, input logic [1:0] tr, input bit w, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd);
        exp_t e;
        hsel   = act;
        htrans = tr;
        hwrite = w;
        haddr  = a;
        hsize  = sz;
        hwdata = next_wdata;
        next_wdata = 32'd0;
        if (act && tr[1]) begin
            e.rd   = !w;
            e.err  = is_err(a, sz);
            e.addr = a;
            e.data = 32'd0;
            if (!e.err) begin
                if (w) model_write(a, sz, wd);
                else e.data = model_read(a);
            end
            if (w) next_wdata = wd;
            exp_q.push_back(e);
        end
        wait_accept();
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        drive(1'b1, 2'b10, 1'b1, a, sz, d);
    endtask
    task automatic rd(input logic [31:0] a, input logic [2:0] sz);
        drive(1'b1, 2'b10, 1'b0, a, sz, 32'd0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 32'd0, 3'd0, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish, required completion");
        $fatal(1);
    end

    initial begin : stim
        int          we0, pend0, low0, cs0;
        logic [31:0] a, old_word;
        logic [2:0]  sz;
        int          kind;

        #2 hresetn = 1'b0;
        #1;
        check("rst_hreadyout", hreadyout, 32'd1);
        check("rst_hresp", hresp, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_mem_ctl", {29'd0, mem_cs, mem_we, wbuf_pending}, 32'd0);
        check("rst_mem_bus", {mem_addr, mem_wstrb} | mem_wdata, 32'd0);
        repeat (3) @(posedge hclk);
        #1 hresetn = 1'b1;
        idle(2);

        // word write then read
        strb_log.delete();
        we0 = we_cnt;
        wr(32'h10, 3'd2, 32'hDEAD_BEEF);
        idle(2);
        rd(32'h10, 3'd2);
        idle(2);
        check("t1_we_pulses", 32'(we_cnt - we0), 32'd1);
        check("t1_wstrb", (strb_log.size() > 0) ? 32'(strb_log[0]) : 32'hFFFF_FFFF, 32'hF);
        check("t1_rdata", last_rd, 32'hDEAD_BEEF);

        // byte and halfword sub-word writes
        strb_log.delete();
        wr(32'h21, 3'd0, 32'h0000_1100);
        idle(1);
        wr(32'h22, 3'd1, 32'hAABB_0000);
        idle(1);
        rd(32'h20, 3'd2);
        idle(2);
        check("t2_wstrb0", (strb_log.size() > 0) ? 32'(strb_log[0]) : 32'hFFFF_FFFF, 32'b0010);
        check("t2_wstrb1", (strb_log.size() > 1) ? 32'(strb_log[1]) : 32'hFFFF_FFFF, 32'b1100);
        check("t2_rdata", last_rd, 32'hAABB_1100);

        // write immediately followed by read of the same word
        pend0 = pend_cnt;
        wr(32'h40, 3'd2, 32'h1234_5678);
        rd(32'h40, 3'd2);
        idle(3);
        check("t3_pending_cycles", 32'(pend_cnt - pend0), 32'd1);
        check("t3_rdata_fwd", last_rd, 32'h1234_5678);

        // sustained alternating W/R over 8 words
        we0  = we_cnt;
        low0 = low_cnt;
        for (int i = 0; i < 32; i++) begin
            a  = 32'h200 + 32'(4 * $urandom_range(0, 7));
            sz = 3'($urandom_range(0, 2));
            a  = a + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
            wr(a, sz, $urandom);
            if (i % 2 == 0) rd(a & ~32'h3, 3'd2);
            else rd(32'h200 + 32'(4 * $urandom_range(0, 7)), 3'd2);
        end
        idle(3);
        check("t4_no_wait_states", 32'(low_cnt - low0), 32'd0);
        check("t4_write_commits", 32'(we_cnt - we0), 32'd32);

        // out-of-range and misaligned accesses
        cs0 = cs_cnt;
        wr(32'h1000, 3'd2, 32'h5A5A_0001);
        idle(3);
`ifdef AHB_SRAM_ERR_EN
        rd(32'h3, 3'd1);
        idle(3);
        check("t5_err_no_mem_cs", 32'(cs_cnt - cs0), 32'd0);
`else
        check("t5_alias_mem_cs", 32'(cs_cnt - cs0), 32'd1);
`endif
        rd(32'h0, 3'd2);
        idle(2);

        // random mixed traffic, including BUSY and odd sizes/alignments
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            a    = 32'h100 + 32'(4 * $urandom_range(0, 15));
            sz   = 3'($urandom_range(0, 2));
            a    = a + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
            if ($urandom_range(0, 7) == 0) begin
                a  = $urandom & 32'h0000_1FFF;
                sz = 3'($urandom_range(0, 3));
            end
            if (kind <= 3) wr(a, sz, $urandom);
            else if (kind <= 7) rd(a, sz);
            else if (kind == 8) idle(1);
            else drive(1'b1, 2'b01, 1'b0, a, sz, 32'd0);
        end
        idle(3);

        // reset while a posted write is pending
        old_word = model_read(32'h40);
        wr(32'h40, 3'd2, 32'hCAFE_F00D);
        rd(32'h40, 3'd2);
        check("t6_pending_before_rst", wbuf_pending, 32'd1);
        we0    = we_cnt;
        hsel   = 1'b0;
        htrans = 2'b00;
        hresetn = 1'b0;
        #1;
        check("t6_rst_pending", wbuf_pending, 32'd0);
        check("t6_rst_ctl", {28'd0, hreadyout, hresp, mem_cs, mem_we}, 32'b1000);
        check("t6_rst_bus", {mem_addr, mem_wstrb} | mem_wdata | hrdata, 32'd0);
        repeat (2) @(posedge hclk);
        exp_q.delete();
        model_set(32'h40, old_word);
        #1 hresetn = 1'b1;
        idle(2);
        check("t6_no_commit", 32'(we_cnt - we0), 32'd0);
        rd(32'h40, 3'd2);
        idle(2);
        check("t6_rdata_old", last_rd, old_word);

        idle(2);
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
